// File: rtl/mem_slot_pkg.sv
// Shared constants for the four-clock memory bus schedule.
// Slot indices double as the legacy-compatible state encoding of busCycle.
package mem_slot_pkg;

  localparam int DEFAULT_ADDR_W = 22;

  localparam logic [1:0] SLOT_VIDEO = 2'd0;
  localparam logic [1:0] SLOT_CPU   = 2'd1;
  localparam logic [1:0] SLOT_EXTRA = 2'd2;
  localparam logic [1:0] SLOT_TURBO = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: the first requester at or after ptr wins.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winIdx
);

  logic found;
  int   idx;

  // Walk the clients in priority order, starting at ptr and wrapping modulo N.
  always_comb begin
    grant  = '0;
    winIdx = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winIdx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot memory arbiter: video on slot 0, CPU on slot 1, extra slots shared
// round-robin by read clients, with per-client base offset and RAM/ROM steering.
module mem_slot_arbiter
  import mem_slot_pkg::*;
#(
  parameter int                              ADDR_W      = DEFAULT_ADDR_W,
  parameter int                              NUM_CLIENTS = 4,
  parameter logic [NUM_CLIENTS*ADDR_W-1:0]   CLIENT_BASE = '0,
  parameter logic [NUM_CLIENTS-1:0]          CLIENT_ROM  = '0
) (
  input  logic                          clk8,
  input  logic                          _reset,
  input  logic                          turbo,
  input  logic [NUM_CLIENTS-1:0]        clientReq,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] clientAddr,
  output logic [NUM_CLIENTS-1:0]        clientAck,
  output logic [1:0]                    busCycle,
  output logic                          videoBusControl,
  output logic                          cpuBusControl,
  output logic                          extraBusControl,
  output logic                          extraValid,
  output logic [ADDR_W-1:0]             extraAddr,
  output logic                          extraRomOE_n,
  output logic                          extraRamOE_n
);

  localparam int PW = $clog2(NUM_CLIENTS);

  logic                   turboQ;
  logic [PW-1:0]          rrPtr;
  logic [NUM_CLIENTS-1:0] grant;
  logic [NUM_CLIENTS-1:0] pickGrant;
  logic [PW-1:0]          pickIdx;
  logic [ADDR_W-1:0]      sumAddr;
  logic                   pickRom;
  logic                   enterExtra;

  rr_arbiter #(.N(NUM_CLIENTS), .PW(PW)) uArb (
    .req    (clientReq),
    .ptr    (rrPtr),
    .grant  (pickGrant),
    .winIdx (pickIdx)
  );

  // turboQ only changes on the 1->2 edge, so slot 3 ownership is already
  // settled by the time the 2->3 edge is evaluated.
  assign enterExtra = (busCycle == SLOT_CPU) ||
                      ((busCycle == SLOT_EXTRA) && !turboQ);

  always_comb begin
    sumAddr = '0;
    pickRom = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (PW'(i) == pickIdx) begin
        sumAddr = CLIENT_BASE[i*ADDR_W +: ADDR_W] + clientAddr[i*ADDR_W +: ADDR_W];
        pickRom = CLIENT_ROM[i];
      end
    end
  end

  // All extra-slot outputs are registered so nothing from clientReq reaches
  // the bus combinationally; they clear on any edge not entering an extra slot.
  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      busCycle     <= SLOT_VIDEO;
      turboQ       <= 1'b0;
      rrPtr        <= '0;
      grant        <= '0;
      extraAddr    <= '0;
      extraRomOE_n <= 1'b1;
      extraRamOE_n <= 1'b1;
    end else begin
      busCycle <= busCycle + 2'd1;
      if (busCycle == SLOT_CPU) begin
        turboQ <= turbo;
      end
      if (enterExtra && (|pickGrant)) begin
        grant        <= pickGrant;
        extraAddr    <= sumAddr;
        extraRomOE_n <= ~pickRom;
        extraRamOE_n <= pickRom;
        rrPtr        <= (pickIdx == PW'(NUM_CLIENTS - 1)) ? '0 : pickIdx + PW'(1);
      end else begin
        grant        <= '0;
        extraAddr    <= '0;
        extraRomOE_n <= 1'b1;
        extraRamOE_n <= 1'b1;
      end
    end
  end

  assign clientAck       = grant;
  assign extraValid      = |grant;
  assign videoBusControl = (busCycle == SLOT_VIDEO);
  assign cpuBusControl   = (busCycle == SLOT_CPU) || ((busCycle == SLOT_TURBO) && turboQ);
  assign extraBusControl = (busCycle == SLOT_EXTRA) || ((busCycle == SLOT_TURBO) && !turboQ);

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed, table-driven bench for mem_slot_arbiter with four clients:
// client 1 reads ROM, client 2's base/address pair exercises the 22-bit wrap.
module tb_mem_slot_arbiter;

  localparam int AW = 22;
  localparam int NC = 4;

  localparam logic [2:0] VID = 3'b100;
  localparam logic [2:0] CPU = 3'b010;
  localparam logic [2:0] EXT = 3'b001;

  typedef struct {
    logic          turbo;
    logic [NC-1:0] req;
    logic [1:0]    expBc;
    logic [2:0]    expCtl;
    logic [NC-1:0] expAck;
    logic [AW-1:0] expAddr;
    logic          expRomN;
    logic          expRamN;
  } vec_t;

  logic                clk8 = 1'b0;
  logic                _reset;
  logic                turbo;
  logic [NC-1:0]       clientReq;
  logic [NC*AW-1:0]    clientAddr;
  logic [NC-1:0]       clientAck;
  logic [1:0]          busCycle;
  logic                videoBusControl;
  logic                cpuBusControl;
  logic                extraBusControl;
  logic                extraValid;
  logic [AW-1:0]       extraAddr;
  logic                extraRomOE_n;
  logic                extraRamOE_n;

  int   testsRun    = 0;
  int   testsFailed = 0;
  vec_t vecs[$];

  always #5 clk8 = ~clk8;

  mem_slot_arbiter #(
    .ADDR_W      (AW),
    .NUM_CLIENTS (NC),
    .CLIENT_BASE ({22'h000000, 22'h3F0000, 22'h100000, 22'h020000}),
    .CLIENT_ROM  (4'b0010)
  ) dut (
    .clk8            (clk8),
    ._reset          (_reset),
    .turbo           (turbo),
    .clientReq       (clientReq),
    .clientAddr      (clientAddr),
    .clientAck       (clientAck),
    .busCycle        (busCycle),
    .videoBusControl (videoBusControl),
    .cpuBusControl   (cpuBusControl),
    .extraBusControl (extraBusControl),
    .extraValid      (extraValid),
    .extraAddr       (extraAddr),
    .extraRomOE_n    (extraRomOE_n),
    .extraRamOE_n    (extraRamOE_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " busCycle"}, 32'(busCycle), 32'(v.expBc));
    checkOutput({tag, " controls"}, 32'({videoBusControl, cpuBusControl, extraBusControl}),
                32'(v.expCtl));
    checkOutput({tag, " clientAck"}, 32'(clientAck), 32'(v.expAck));
    checkOutput({tag, " extraValid"}, 32'(extraValid), 32'(|v.expAck));
    checkOutput({tag, " extraAddr"}, 32'(extraAddr), 32'(v.expAddr));
    checkOutput({tag, " oeRomRam"}, 32'({extraRomOE_n, extraRamOE_n}),
                32'({v.expRomN, v.expRamN}));
  endtask

  // Inputs are driven between edges, then outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input string tag, input vec_t v);
    turbo     = v.turbo;
    clientReq = v.req;
    @(posedge clk8);
    #1;
    checkAll(tag, v);
  endtask

  task automatic addVec(input logic t, input logic [NC-1:0] r, input logic [1:0] bc,
                        input logic [2:0] ctl, input logic [NC-1:0] ack,
                        input logic [AW-1:0] addr, input logic romN, input logic ramN);
    vec_t v;
    v.turbo = t; v.req = r; v.expBc = bc; v.expCtl = ctl;
    v.expAck = ack; v.expAddr = addr; v.expRomN = romN; v.expRamN = ramN;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;

    // Each row: inputs held before the edge, expected outputs after it.
    addVec(0, 4'h0, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'h0, 2'd2, EXT, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'h0, 2'd3, EXT, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'h0, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd2, EXT, 4'b0001, 22'h020100, 1, 0);
    addVec(0, 4'hF, 2'd3, EXT, 4'b0010, 22'h100200, 0, 1);
    addVec(0, 4'hF, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd2, EXT, 4'b0100, 22'h010000, 1, 0);
    addVec(0, 4'hF, 2'd3, EXT, 4'b1000, 22'h000300, 1, 0);
    addVec(0, 4'hF, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'hF, 2'd2, EXT, 4'b0001, 22'h020100, 1, 0);
    addVec(1, 4'hF, 2'd3, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'hF, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'hF, 2'd2, EXT, 4'b0010, 22'h100200, 0, 1);
    // turbo dropped during slot 2 must not reach this slot 3
    addVec(0, 4'hF, 2'd3, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'hF, 2'd2, EXT, 4'b0100, 22'h010000, 1, 0);
    addVec(0, 4'hF, 2'd3, EXT, 4'b1000, 22'h000300, 1, 0);
    addVec(0, 4'h2, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'h2, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(0, 4'h2, 2'd2, EXT, 4'b0010, 22'h100200, 0, 1);
    addVec(0, 4'h2, 2'd3, EXT, 4'b0010, 22'h100200, 0, 1);
    addVec(1, 4'h1, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'h1, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'h1, 2'd2, EXT, 4'b0001, 22'h020100, 1, 0);
    addVec(1, 4'h1, 2'd3, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'h1, 2'd0, VID, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'h1, 2'd1, CPU, 4'b0000, 22'h000000, 1, 1);
    addVec(1, 4'h1, 2'd2, EXT, 4'b0001, 22'h020100, 1, 0);

    _reset     = 1'b0;
    turbo      = 1'b0;
    clientReq  = '0;
    clientAddr = {22'h000300, 22'h020000, 22'h000200, 22'h000100};
    repeat (2) @(posedge clk8);
    #1;
    v = '{1'b0, 4'h0, 2'd0, VID, 4'b0000, 22'h000000, 1'b1, 1'b1};
    checkAll("reset", v);

    @(negedge clk8);
    _reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // The table ends inside a granted slot 2 with rrPtr=1 and turboQ=1.
    turbo     = 1'b0;
    clientReq = 4'hF;
    _reset    = 1'b0;
    #1;
    v = '{1'b0, 4'hF, 2'd0, VID, 4'b0000, 22'h000000, 1'b1, 1'b1};
    checkAll("midReset", v);
    @(negedge clk8);
    _reset = 1'b1;
    applyStimulus("postReset1", '{1'b0, 4'hF, 2'd1, CPU, 4'b0000, 22'h000000, 1'b1, 1'b1});
    applyStimulus("postReset2", '{1'b0, 4'hF, 2'd2, EXT, 4'b0001, 22'h020100, 1'b1, 1'b0});
    applyStimulus("postReset3", '{1'b0, 4'hF, 2'd3, EXT, 4'b0010, 22'h100200, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
